// File: rtl/extram_arbiter_wb8_pkg.sv
// Shared definitions for the external SRAM arbiter: default address width and
// the Wishbone-side FSM encoding.
package extram_arbiter_wb8_pkg;

   localparam int ADDR_WIDTH_DEF = 19;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_ACK  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/extram_arbiter_wb8.sv
// Arbiter for the 8-bit async SRAM: video fetches win every cycle they appear,
// single Wishbone byte accesses fill the remaining idle cycles.
module extram_arbiter_wb8
   import extram_arbiter_wb8_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  I_clk,
   input  logic                  I_reset_n,
   input  logic                  I_vid_req,
   input  logic [ADDR_WIDTH-1:0] I_vid_adr,
   output logic [7:0]            O_vid_dat,
   input  logic [ADDR_WIDTH-1:0] I_wb_adr,
   input  logic [7:0]            I_wb_dat,
   input  logic                  I_wb_stb,
   input  logic                  I_wb_we,
   output logic                  O_wb_ack,
   output logic [7:0]            O_wb_dat,
   output logic [ADDR_WIDTH-1:0] O_sram_adr,
   output logic                  O_sram_ce_n,
   output logic                  O_sram_oe_n,
   output logic                  O_sram_we_n,
   inout  wire  [7:0]            IO_sram_dat
);

   wb_state_t             state_reg, state_next;
   logic [ADDR_WIDTH-1:0] wb_adr_reg;
   logic [ADDR_WIDTH-1:0] last_adr_reg;
   logic [7:0]            wb_dat_reg;
   logic                  wb_we_reg;
   logic                  vid_acc;
   logic                  wb_acc;
   logic                  wb_wr;
   logic                  wb_take;

   // Access qualifiers; reset masks every strobe regardless of requests.
   always_comb begin
      vid_acc = I_vid_req && I_reset_n;
      wb_acc  = (state_reg == ST_PEND) && !I_vid_req && I_reset_n;
      wb_wr   = wb_acc && wb_we_reg;
      wb_take = (state_reg == ST_IDLE) && I_wb_stb && !O_wb_ack;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (wb_take) state_next = ST_PEND;
         ST_PEND: if (!I_vid_req) state_next = ST_ACK;
         ST_ACK:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      O_sram_ce_n = !(vid_acc || wb_acc);
      O_sram_oe_n = !(vid_acc || (wb_acc && !wb_we_reg));
      O_sram_we_n = !wb_wr;
      if (vid_acc)
         O_sram_adr = I_vid_adr;
      else if (wb_acc)
         O_sram_adr = wb_adr_reg;
      else
         O_sram_adr = last_adr_reg;
   end

   assign IO_sram_dat = wb_wr ? wb_dat_reg : 8'bz;

   always_ff @(posedge I_clk) begin
      if (!I_reset_n) begin
         state_reg    <= ST_IDLE;
         O_wb_ack     <= 1'b0;
         O_wb_dat     <= 8'h00;
         O_vid_dat    <= 8'h00;
         last_adr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         O_wb_ack     <= wb_acc;
         last_adr_reg <= O_sram_adr;
         if (vid_acc)
            O_vid_dat <= IO_sram_dat;
         if (wb_acc && !wb_we_reg)
            O_wb_dat <= IO_sram_dat;
      end
   end

   // Request capture needs no reset: it is only consumed from PEND.
   always_ff @(posedge I_clk) begin
      if (wb_take) begin
         wb_adr_reg <= I_wb_adr;
         wb_dat_reg <= I_wb_dat;
         wb_we_reg  <= I_wb_we;
      end
   end

endmodule

// File: tb/tb_extram_arbiter_wb8.sv
// Randomized bench for extram_arbiter_wb8 with an async SRAM model and a
// transaction-level reference of expected memory contents and responses.
module tb_extram_arbiter_wb8;

   localparam int AW    = 19;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_adr = '0;
   logic [7:0]    vid_dat;
   logic [AW-1:0] wb_adr = '0;
   logic [7:0]    wb_wdat = '0;
   logic          wb_stb = 1'b0;
   logic          wb_we = 1'b0;
   logic          wb_ack;
   logic [7:0]    wb_rdat;
   logic [AW-1:0] sram_adr;
   logic          sram_ce_n, sram_oe_n, sram_we_n;
   wire  [7:0]    sram_dat;

   always #5 clk = ~clk;

   extram_arbiter_wb8 #(.ADDR_WIDTH(AW)) dut (
      .I_clk       (clk),
      .I_reset_n   (reset_n),
      .I_vid_req   (vid_req),
      .I_vid_adr   (vid_adr),
      .O_vid_dat   (vid_dat),
      .I_wb_adr    (wb_adr),
      .I_wb_dat    (wb_wdat),
      .I_wb_stb    (wb_stb),
      .I_wb_we     (wb_we),
      .O_wb_ack    (wb_ack),
      .O_wb_dat    (wb_rdat),
      .O_sram_adr  (sram_adr),
      .O_sram_ce_n (sram_ce_n),
      .O_sram_oe_n (sram_oe_n),
      .O_sram_we_n (sram_we_n),
      .IO_sram_dat (sram_dat)
   );

   // Async SRAM device: combinational read, write committed at the clock edge.
   logic [7:0] sram_mem [0:DEPTH-1];
   assign sram_dat = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_adr] : 8'bz;
   always @(posedge clk)
      if (!sram_ce_n && !sram_we_n)
         sram_mem[sram_adr] <= sram_dat;

   // Reference: what memory should hold and what the outputs should show.
   logic [7:0]    ref_mem [0:DEPTH-1];
   logic [7:0]    exp_vid_dat, exp_wb_dat;
   logic          exp_ack;
   logic          m_queued, m_we, m_known;
   logic [AW-1:0] m_adr, m_last;
   logic [7:0]    m_dat;
   logic          chk_regs;

   // Wishbone master
   logic          mst_busy, mst_we;
   logic [AW-1:0] mst_adr;
   logic [7:0]    mst_dat;
   int            mst_age;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic mst_start(input logic [AW-1:0] a, input logic [7:0] d, input logic we);
      mst_busy = 1'b1;
      mst_adr  = a;
      mst_dat  = d;
      mst_we   = we;
      mst_age  = 0;
   endtask

   task automatic step(input logic rst_v, input logic vreq_v, input logic [AW-1:0] vadr_v);
      logic ack_obs, acc_v, acc_w;
      ack_obs = wb_ack;
      if (chk_regs) begin
         chk("vid_dat", vid_dat, exp_vid_dat);
         chk("wb_ack", wb_ack, exp_ack);
         chk("wb_dat", wb_rdat, exp_wb_dat);
      end
      reset_n = rst_v;
      vid_req = vreq_v;
      vid_adr = vadr_v;
      wb_stb  = mst_busy;
      wb_we   = mst_we;
      wb_adr  = mst_adr;
      wb_wdat = mst_dat;
      #2;
      acc_v = rst_v && vreq_v;
      acc_w = rst_v && m_queued && !vreq_v;
      chk("ce_n", sram_ce_n, !(acc_v || acc_w));
      chk("oe_n", sram_oe_n, !(acc_v || (acc_w && !m_we)));
      chk("we_n", sram_we_n, !(acc_w && m_we));
      chk("we_oe_excl", sram_we_n | sram_oe_n, 1'b1);
      if (acc_v)
         chk("adr_vid", sram_adr, vadr_v);
      else if (acc_w)
         chk("adr_wb", sram_adr, m_adr);
      else if (rst_v && m_known)
         chk("adr_hold", sram_adr, m_last);
      if (acc_w && m_we)
         chk("wr_bus", sram_dat, m_dat);

      if (!rst_v) begin
         m_queued    = 1'b0;
         exp_ack     = 1'b0;
         exp_vid_dat = 8'h00;
         exp_wb_dat  = 8'h00;
         m_known     = 1'b0;
      end else begin
         if (acc_v) begin
            exp_vid_dat = ref_mem[vadr_v];
            m_last = vadr_v;
            m_known = 1'b1;
         end
         if (acc_w) begin
            if (m_we) ref_mem[m_adr] = m_dat;
            else      exp_wb_dat = ref_mem[m_adr];
            m_last = m_adr;
            m_known = 1'b1;
            m_queued = 1'b0;
         end else if (!m_queued && !exp_ack && wb_stb) begin
            m_queued = 1'b1;
            m_adr = wb_adr;
            m_dat = wb_wdat;
            m_we  = wb_we;
         end
         exp_ack = acc_w;
      end

      if (!rst_v) begin
         mst_busy = 1'b0;
      end else if (ack_obs && mst_busy) begin
         $display("wb %s adr=%05h dat=%02h t=%0t", mst_we ? "WR" : "RD", mst_adr,
                  mst_we ? mst_dat : wb_rdat, $time);
         mst_busy = 1'b0;
      end else if (mst_busy) begin
         mst_age++;
         if (mst_age > 400) begin
            chk("wb_timeout", mst_age, 0);
            mst_busy = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (!rst_v) chk_regs = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while (mst_busy && n < 500) begin
         step(1'b1, 1'b0, '0);
         n++;
      end
      step(1'b1, 1'b0, '0);
   endtask

   initial begin
      logic [7:0] b;
      int nwr;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         sram_mem[i] = b;
         ref_mem[i]  = b;
      end
      mst_busy = 1'b0; mst_we = 1'b0; mst_adr = '0; mst_dat = '0; mst_age = 0;
      m_queued = 1'b0; m_we = 1'b0; m_known = 1'b0; m_adr = '0; m_last = '0; m_dat = '0;
      exp_vid_dat = '0; exp_wb_dat = '0; exp_ack = 1'b0; chk_regs = 1'b0;
      @(posedge clk);
      #1;

      // Reset with a video request asserted
      $display("phase reset");
      step(1'b0, 1'b1, 19'h12345);
      step(1'b0, 1'b1, 19'h12345);
      step(1'b1, 1'b0, '0);

      // Single video read, data held afterwards
      $display("phase video read");
      sram_mem[19'h20000] = 8'hA5;
      ref_mem[19'h20000]  = 8'hA5;
      step(1'b1, 1'b1, 19'h20000);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      chk("vid_a5", vid_dat, 8'hA5);

      // Wishbone write in idle
      $display("phase wb write");
      mst_start(19'h00010, 8'h3C, 1'b1);
      drain();
      chk("mem_10", sram_mem[19'h00010], 8'h3C);

      // Pending read stalled by six video cycles
      $display("phase contention");
      sram_mem[19'h00777] = 8'h5A;
      ref_mem[19'h00777]  = 8'h5A;
      mst_start(19'h00777, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 19'(32 + i));
      drain();
      chk("rd_5a", wb_rdat, 8'h5A);

      // Video every second cycle with interleaved writes
      $display("phase graphics");
      nwr = 0;
      for (int i = 0; i < 128; i++) begin
         if (!mst_busy && nwr < 8 && i > 2) begin
            mst_start(19'($urandom_range(0, 63)), 8'($urandom), 1'b1);
            nwr++;
         end
         step(1'b1, (i % 2) == 0, 19'($urandom_range(0, 63)));
      end
      drain();

      // Reset while a write is pending behind video traffic
      $display("phase reset in pend");
      mst_start(19'h00100, 8'h77, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 19'h00200);
      step(1'b0, 1'b1, 19'h00200);
      step(1'b0, 1'b1, 19'h00200);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      chk("abort_mem", sram_mem[19'h00100], ref_mem[19'h00100]);
      mst_start(19'h00100, 8'h78, 1'b1);
      drain();
      chk("mem_100", sram_mem[19'h00100], 8'h78);

      // Random mixed traffic over a small address window
      $display("phase random");
      for (int i = 0; i < 1500; i++) begin
         if (!mst_busy && $urandom_range(0, 3) == 0)
            mst_start(19'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)));
         step(1'b1, $urandom_range(0, 99) < 60, 19'($urandom_range(0, 31)));
      end
      drain();
      for (int i = 0; i < 32; i++)
         chk("final_mem", sram_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
